led_bank_ctrl: RTL

LED_BANK_CTRL -- requirements
Module: led_bank_ctrl

---
 rtl/led_bank_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/led_bank_ctrl.sv
// LED bank: per-channel off/on/blink/breathe PWM with a tick-timed override window (LED_GAMMA_EN: square-law breathe duty).
// Outputs registered, 1 cycle after inputs; no backpressure, tick and fault_req are single-cycle strobes.
module led_bank_ctrl #(
  parameter int                NUM_CH      = 4,
  parameter int                PWM_BITS    = 10,
  parameter int                BLINK_TICKS = 15,
  parameter logic [NUM_CH-1:0] OVR_MASK    = 4'b1010
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  fault_req,
  input  logic [2*NUM_CH-1:0]   ch_mode,
  output logic [NUM_CH-1:0]     led_out,
  output logic                  override_active
);

  localparam int RW   = PWM_BITS + 1;
  localparam int OFFS = (1 << RW) / NUM_CH;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_OVR    = 2'd1,
    ST_NORMAL = 2'd2
  } state_t;

  state_t                             state, state_nxt;
  logic [PWM_BITS-1:0]                pwm_cnt;
  logic [RW-1:0]                      ramp;
  logic [NUM_CH-1:0][PWM_BITS-1:0]    duty;
  logic [NUM_CH-1:0][PWM_BITS-1:0]    duty_nxt;
  logic                               blink_ph;
  logic [5:0]                         ovr_cnt, ovr_cnt_nxt;
  logic                               ovr_ph, ovr_ph_nxt;
  logic [NUM_CH-1:0]                  led_nxt;
  logic                               wrap;

  assign wrap = &pwm_cnt;

  // Each channel's triangle is a phase-shifted fold of the shared ramp.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [RW-1:0]       r;
    logic [PWM_BITS-1:0] t;
    assign r = ramp + RW'(g * OFFS);
    assign t = r[RW-1] ? ~r[PWM_BITS-1:0] : r[PWM_BITS-1:0];
`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    assign sq          = t * t;
    assign duty_nxt[g] = sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty_nxt[g] = t;
`endif
  end

  always_comb begin
    state_nxt   = state;
    ovr_cnt_nxt = ovr_cnt;
    ovr_ph_nxt  = ovr_ph;
    led_nxt     = '0;

    if (fault_req || state == ST_START) begin
      state_nxt   = ST_OVR;
      ovr_cnt_nxt = '0;
      ovr_ph_nxt  = 1'b0;
    end else if (state == ST_OVR) begin
      if (ovr_cnt == 6'(BLINK_TICKS)) begin
        state_nxt = ST_NORMAL;
      end else if (tick) begin
        ovr_cnt_nxt = ovr_cnt + 6'd1;
        ovr_ph_nxt  = ~ovr_ph;
      end
    end

    // The start cycle shows the override pattern with ovr_ph still 0, i.e. dark.
    if (state != ST_NORMAL) begin
      led_nxt = ovr_ph ? OVR_MASK : '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (ch_mode[2*i +: 2])
          2'b00:   led_nxt[i] = 1'b0;
          2'b01:   led_nxt[i] = 1'b1;
          2'b10:   led_nxt[i] = blink_ph;
          default: led_nxt[i] = (pwm_cnt < duty[i]);
        endcase
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state           <= ST_START;
      pwm_cnt         <= '0;
      ramp            <= '0;
      duty            <= '0;
      blink_ph        <= 1'b0;
      ovr_cnt         <= '0;
      ovr_ph          <= 1'b0;
      led_out         <= '0;
      override_active <= 1'b0;
    end else begin
      state           <= state_nxt;
      pwm_cnt         <= pwm_cnt + 1'b1;
      if (wrap) begin
        ramp <= ramp + 1'b1;
        duty <= duty_nxt;
      end
      if (tick) begin
        blink_ph <= ~blink_ph;
      end
      ovr_cnt         <= ovr_cnt_nxt;
      ovr_ph          <= ovr_ph_nxt;
      led_out         <= led_nxt;
      override_active <= (state_nxt == ST_OVR);
    end
  end

endmodule
